// File: rtl/ddr3_csr_bank.sv
// ddr3_csr_bank: single-clock CSR bank for DDR3 frame-buffer offsets and test control.
// Holds NUM_BUF buffer offsets with full flags, a DATA_W-wide test data path and two
// independent test channels (write/read), each with busy, timeout and sticky errors.
// Optional build macro: DDR3_CSR_IRQ_EN adds IRQ_MASK at 0x06, sticky done bits ERR[4:3]
// and a registered interrupt. Without it irq is tied low and 0x06 is unmapped.
module ddr3_csr_bank #(
    parameter int unsigned NUM_BUF = 2,
    parameter int unsigned OFFS_W  = 26,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TMO_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      csr_read,
    input  logic                      csr_write,
    input  logic [7:0]                csr_addr,
    input  logic [31:0]               csr_wr_data,
    output logic [31:0]               csr_rd_data,
    output logic [NUM_BUF*OFFS_W-1:0] buf_offset,
    output logic [NUM_BUF-1:0]        buf_full,
    input  logic [NUM_BUF-1:0]        clear_buffer,
    output logic [31:0]               test_addr,
    output logic [DATA_W-1:0]         test_wr_data,
    input  logic [DATA_W-1:0]         test_rd_data,
    output logic                      test_wr,
    output logic                      test_rd,
    input  logic                      wr_finish,
    input  logic                      rd_finish,
    output logic                      wr_busy,
    output logic                      rd_busy,
    output logic                      test_pat,
    output logic                      irq
);

    localparam int unsigned W = DATA_W / 32;

    localparam logic [31:0] IdValue = 32'hB00BB00B;

    localparam logic [7:0] AddrId        = 8'h00;
    localparam logic [7:0] AddrBufStatus = 8'h01;
    localparam logic [7:0] AddrCmd       = 8'h02;
    localparam logic [7:0] AddrErr       = 8'h03;
    localparam logic [7:0] AddrTestAddr  = 8'h04;
    localparam logic [7:0] AddrTmo       = 8'h05;
    localparam logic [7:0] AddrIrqMask   = 8'h06;
    localparam logic [7:0] AddrOffsBase  = 8'h10;
    localparam logic [7:0] AddrWdatBase  = 8'h20;
    localparam logic [7:0] AddrRdatBase  = 8'h30;

    localparam logic [TMO_W-1:0] TmoOne = TMO_W'(1);

`ifdef DDR3_CSR_IRQ_EN
    localparam logic DoneEn = 1'b1;
    logic [4:0] mask_q, mask_d;
    logic       irq_q, irq_d;
`else
    localparam logic DoneEn = 1'b0;
`endif

    // Channel index 0 is the write test channel, 1 is the read test channel.
    typedef enum logic {ChIdle = 1'b0, ChBusy = 1'b1} ch_state_e;

    ch_state_e        ch_st_q [2];
    ch_state_e        ch_st_d [2];
    logic [TMO_W-1:0] cnt_q   [2];
    logic [TMO_W-1:0] cnt_d   [2];
    logic [1:0]       pulse_q, pulse_d;
    logic [1:0]       ch_start, ch_fin;
    logic [1:0]       ch_busy_err, ch_tmo, ch_done;
    logic [1:0]       ch_busy;

    logic [NUM_BUF-1:0]             buf_full_q, buf_full_d;
    logic [NUM_BUF-1:0][OFFS_W-1:0] offs_q, offs_d;
    logic [31:0]                    taddr_q, taddr_d;
    logic [TMO_W-1:0]               tmo_q, tmo_d;
    logic [W-1:0][31:0]             wdat_q, wdat_d;
    logic                           pat_q, pat_d;
    logic [4:0]                     err_q, err_d;
    logic [4:0]                     err_set, err_clr;
    logic [31:0]                    rd_data_q, rd_data_d;
    logic [31:0]                    rd_val;

    // Decode CMD writes into per-channel start requests.
    always_comb begin
        ch_start    = '0;
        ch_fin      = {rd_finish, wr_finish};
        if (csr_write && (csr_addr == AddrCmd)) begin
            ch_start = csr_wr_data[1:0];
        end
    end

    // Channel next-state: start from idle, finish or timeout from busy.
    always_comb begin
        ch_busy_err = '0;
        ch_tmo      = '0;
        ch_done     = '0;
        pulse_d     = '0;
        for (int c = 0; c < 2; c++) begin
            ch_st_d[c] = ch_st_q[c];
            cnt_d[c]   = cnt_q[c];
            case (ch_st_q[c])
                ChIdle: begin
                    if (ch_start[c]) begin
                        ch_st_d[c] = ChBusy;
                        cnt_d[c]   = '0;
                        pulse_d[c] = 1'b1;
                    end
                end
                ChBusy: begin
                    // A re-start while busy only flags an error; the count keeps running.
                    ch_busy_err[c] = ch_start[c];
                    if (ch_fin[c]) begin
                        ch_st_d[c] = ChIdle;
                        ch_done[c] = 1'b1;
                    end else if ((tmo_q != '0) && (cnt_q[c] >= (tmo_q - TmoOne))) begin
                        // >= also catches a limit lowered below the running count.
                        ch_st_d[c] = ChIdle;
                        ch_tmo[c]  = 1'b1;
                    end else if (cnt_q[c] != '1) begin
                        cnt_d[c] = cnt_q[c] + TmoOne;
                    end
                end
                default: ch_st_d[c] = ChIdle;
            endcase
        end
    end

    // Channel outputs decoded from state.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ch_busy[c] = (ch_st_q[c] == ChBusy);
        end
    end

    // Channel state, counters and start pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                ch_st_q[c] <= ChIdle;
                cnt_q[c]   <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                ch_st_q[c] <= ch_st_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            pulse_q <= pulse_d;
        end
    end

    // Sticky error/done bits; a hardware set beats a simultaneous W1C.
    always_comb begin
        err_set      = '0;
        err_set[0]   = |ch_busy_err;
        err_set[2:1] = ch_tmo;
        err_set[4:3] = ch_done & {2{DoneEn}};
        err_clr      = '0;
        if (csr_write && (csr_addr == AddrErr)) begin
            err_clr = csr_wr_data[4:0];
        end
        err_d = (err_q & ~err_clr) | err_set;
    end

    // Software-visible register next-state.
    always_comb begin
        // W1S beats clear_buffer on the same bit.
        buf_full_d = buf_full_q & ~clear_buffer;
        offs_d     = offs_q;
        taddr_d    = taddr_q;
        tmo_d      = tmo_q;
        wdat_d     = wdat_q;
        pat_d      = pat_q;
        if (csr_write) begin
            if (csr_addr == AddrBufStatus) begin
                buf_full_d = buf_full_d | csr_wr_data[NUM_BUF-1:0];
            end
            if (csr_addr == AddrCmd) begin
                pat_d = csr_wr_data[2];
            end
            if (csr_addr == AddrTestAddr) begin
                taddr_d = csr_wr_data;
            end
            if (csr_addr == AddrTmo) begin
                tmo_d = csr_wr_data[TMO_W-1:0];
            end
            for (int i = 0; i < NUM_BUF; i++) begin
                if (csr_addr == (AddrOffsBase + 8'(i))) begin
                    offs_d[i] = csr_wr_data[OFFS_W-1:0];
                end
            end
            for (int j = 0; j < W; j++) begin
                if (csr_addr == (AddrWdatBase + 8'(j))) begin
                    wdat_d[j] = csr_wr_data;
                end
            end
        end
    end

    // Read mux over pre-write state; unmapped addresses return zero.
    always_comb begin
        rd_val = '0;
        case (csr_addr)
            AddrId:        rd_val = IdValue;
            AddrBufStatus: rd_val[NUM_BUF-1:0] = buf_full_q;
            AddrCmd:       rd_val[2:0] = {pat_q, ch_busy[1], ch_busy[0]};
            AddrErr:       rd_val[4:0] = err_q;
            AddrTestAddr:  rd_val = taddr_q;
            AddrTmo:       rd_val[TMO_W-1:0] = tmo_q;
`ifdef DDR3_CSR_IRQ_EN
            AddrIrqMask:   rd_val[4:0] = mask_q;
`endif
            default:       rd_val = '0;
        endcase
        for (int i = 0; i < NUM_BUF; i++) begin
            if (csr_addr == (AddrOffsBase + 8'(i))) begin
                rd_val[OFFS_W-1:0] = offs_q[i];
            end
        end
        for (int j = 0; j < W; j++) begin
            if (csr_addr == (AddrWdatBase + 8'(j))) begin
                rd_val = wdat_q[j];
            end
            if (csr_addr == (AddrRdatBase + 8'(j))) begin
                rd_val = test_rd_data[j*32 +: 32];
            end
        end
        rd_data_d = csr_read ? rd_val : rd_data_q;
    end

    // CSR storage and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full_q <= '0;
            offs_q     <= '0;
            taddr_q    <= '0;
            tmo_q      <= '0;
            wdat_q     <= '0;
            pat_q      <= 1'b0;
            err_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            offs_q     <= offs_d;
            taddr_q    <= taddr_d;
            tmo_q      <= tmo_d;
            wdat_q     <= wdat_d;
            pat_q      <= pat_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef DDR3_CSR_IRQ_EN
    // Mask register and interrupt, one cycle behind the ERR update.
    always_comb begin
        mask_d = mask_q;
        if (csr_write && (csr_addr == AddrIrqMask)) begin
            mask_d = csr_wr_data[4:0];
        end
        irq_d = |(err_q & mask_q);
    end

    // Interrupt state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign csr_rd_data  = rd_data_q;
    assign buf_offset   = offs_q;
    assign buf_full     = buf_full_q;
    assign test_addr    = taddr_q;
    assign test_wr_data = wdat_q;
    assign test_wr      = pulse_q[0];
    assign test_rd      = pulse_q[1];
    assign wr_busy      = ch_busy[0];
    assign rd_busy      = ch_busy[1];
    assign test_pat     = pat_q;

endmodule

// File: tb/tb_ddr3_csr_bank.sv
// Bench for ddr3_csr_bank: directed checks with literal expectations, then randomized
// CSR and handshake traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_ddr3_csr_bank;
    localparam int NB = 4;
    localparam int OW = 26;
    localparam int DW = 128;
    localparam int TW = 16;
    localparam int NW = DW / 32;

    logic            clk          = 1'b0;
    logic            reset_n      = 1'b0;
    logic            csr_read     = 1'b0;
    logic            csr_write    = 1'b0;
    logic [7:0]      csr_addr     = '0;
    logic [31:0]     csr_wr_data  = '0;
    logic [31:0]     csr_rd_data;
    logic [NB*OW-1:0] buf_offset;
    logic [NB-1:0]   buf_full;
    logic [NB-1:0]   clear_buffer = '0;
    logic [31:0]     test_addr;
    logic [DW-1:0]   test_wr_data;
    logic [DW-1:0]   test_rd_data = '0;
    logic            test_wr, test_rd;
    logic            wr_finish    = 1'b0;
    logic            rd_finish    = 1'b0;
    logic            wr_busy, rd_busy, test_pat, irq;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] addr_tab [0:19] = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04,
                                    8'h05, 8'h06, 8'h07, 8'h10, 8'h11, 8'h13, 8'h14, 8'h20,
                                    8'h23, 8'h24, 8'h30, 8'h33};

    always #5 clk = ~clk;

    ddr3_csr_bank #(
        .NUM_BUF (NB),
        .OFFS_W  (OW),
        .DATA_W  (DW),
        .TMO_W   (TW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .csr_read     (csr_read),
        .csr_write    (csr_write),
        .csr_addr     (csr_addr),
        .csr_wr_data  (csr_wr_data),
        .csr_rd_data  (csr_rd_data),
        .buf_offset   (buf_offset),
        .buf_full     (buf_full),
        .clear_buffer (clear_buffer),
        .test_addr    (test_addr),
        .test_wr_data (test_wr_data),
        .test_rd_data (test_rd_data),
        .test_wr      (test_wr),
        .test_rd      (test_rd),
        .wr_finish    (wr_finish),
        .rd_finish    (rd_finish),
        .wr_busy      (wr_busy),
        .rd_busy      (rd_busy),
        .test_pat     (test_pat),
        .irq          (irq)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]   m_rd;
    logic [NB-1:0] m_full;
    logic [OW-1:0] m_offs [NB];
    logic [31:0]   m_taddr;
    logic [TW-1:0] m_tmo;
    logic [31:0]   m_wd [NW];
    logic          m_pat;
    logic [1:0]    m_busy;
    longint        m_start [2];
    longint        cyc;
    logic [4:0]    m_err;
    logic [4:0]    m_mask;
    logic          m_irq;
    logic [1:0]    m_pulse;

    function automatic logic [31:0] m_lookup(input logic [7:0] a);
        int ia = int'(a);
        logic [31:0] v = 32'h0;
        if (ia == 0) v = 32'hB00BB00B;
        if (ia == 1) v = 32'(m_full);
        if (ia == 2) v = {29'd0, m_pat, m_busy[1], m_busy[0]};
        if (ia == 3) v = {27'd0, m_err};
        if (ia == 4) v = m_taddr;
        if (ia == 5) v = 32'(m_tmo);
`ifdef DDR3_CSR_IRQ_EN
        if (ia == 6) v = {27'd0, m_mask};
`endif
        if (ia >= 16 && ia < 16 + NB) v = 32'(m_offs[ia - 16]);
        if (ia >= 32 && ia < 32 + NW) v = m_wd[ia - 32];
        if (ia >= 48 && ia < 48 + NW) v = test_rd_data[(ia - 48) * 32 +: 32];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rd = '0; m_full = '0; m_taddr = '0; m_tmo = '0; m_pat = 1'b0;
            m_busy = '0; m_err = '0; m_mask = '0; m_irq = 1'b0; m_pulse = '0; cyc = 0;
            for (int i = 0; i < NB; i++) m_offs[i] = '0;
            for (int j = 0; j < NW; j++) m_wd[j] = '0;
            m_start[0] = 0; m_start[1] = 0;
        end else begin
            logic [4:0] set;
            logic [4:0] clr;
            logic [1:0] start;
            logic [1:0] fin;
            int ia;
            cyc++;
            if (csr_read) m_rd = m_lookup(csr_addr);
`ifdef DDR3_CSR_IRQ_EN
            m_irq = |(m_err & m_mask);
`endif
            start[0] = csr_write && (csr_addr == 8'h02) && csr_wr_data[0];
            start[1] = csr_write && (csr_addr == 8'h02) && csr_wr_data[1];
            fin = {rd_finish, wr_finish};
            set = '0;
            m_pulse = '0;
            for (int c = 0; c < 2; c++) begin
                if (!m_busy[c]) begin
                    if (start[c]) begin
                        m_busy[c] = 1'b1; m_start[c] = cyc; m_pulse[c] = 1'b1;
                    end
                end else begin
                    if (start[c]) set[0] = 1'b1;
                    if (fin[c]) begin
                        m_busy[c] = 1'b0;
`ifdef DDR3_CSR_IRQ_EN
                        set[3 + c] = 1'b1;
`endif
                    end else if (m_tmo != 0 && (cyc - m_start[c]) >= longint'(m_tmo)) begin
                        // Timed out after m_tmo full busy cycles.
                        m_busy[c] = 1'b0; set[1 + c] = 1'b1;
                    end
                end
            end
            clr = (csr_write && csr_addr == 8'h03) ? csr_wr_data[4:0] : 5'd0;
            m_err = (m_err & ~clr) | set;
            m_full = m_full & ~clear_buffer;
            if (csr_write) begin
                ia = int'(csr_addr);
                if (ia == 1) m_full = m_full | csr_wr_data[NB-1:0];
                if (ia == 2) m_pat = csr_wr_data[2];
                if (ia == 4) m_taddr = csr_wr_data;
                if (ia == 5) m_tmo = csr_wr_data[TW-1:0];
`ifdef DDR3_CSR_IRQ_EN
                if (ia == 6) m_mask = csr_wr_data[4:0];
`endif
                if (ia >= 16 && ia < 16 + NB) m_offs[ia - 16] = csr_wr_data[OW-1:0];
                if (ia >= 32 && ia < 32 + NW) m_wd[ia - 32] = csr_wr_data;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [NB*OW-1:0] exp_offs;
        logic [DW-1:0]    exp_wd;
        for (int i = 0; i < NB; i++) exp_offs[i*OW +: OW] = m_offs[i];
        for (int j = 0; j < NW; j++) exp_wd[j*32 +: 32] = m_wd[j];
        chk("csr_rd_data", csr_rd_data, m_rd);
        chk("buf_offset", buf_offset, exp_offs);
        chk("buf_full", buf_full, m_full);
        chk("test_addr", test_addr, m_taddr);
        chk("test_wr_data", test_wr_data, exp_wd);
        chk("test_wr", test_wr, m_pulse[0]);
        chk("test_rd", test_rd, m_pulse[1]);
        chk("wr_busy", wr_busy, m_busy[0]);
        chk("rd_busy", rd_busy, m_busy[1]);
        chk("test_pat", test_pat, m_pat);
        chk("irq", irq, m_irq);
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        csr_write = 1'b1; csr_addr = a; csr_wr_data = d;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        csr_read = 1'b1; csr_addr = a;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_rd_data;
    endtask

    initial begin
        logic [31:0] d;
        int n;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        rd(8'h00, d); chk("id", d, 32'hB00BB00B);
        rd(8'h01, d); chk("buf_status_rst", d, 32'h0);
        rd(8'h02, d); chk("cmd_rst", d, 32'h0);
        rd(8'h03, d); chk("err_rst", d, 32'h0);

        wr(8'h12, 32'h0123_4567);
        chk("offs2", buf_offset[2*OW +: OW], 26'h123_4567);
        wr(8'h01, 32'hA);
        chk("full_w1s", buf_full, 4'b1010);
        csr_write = 1'b1; csr_addr = 8'h01; csr_wr_data = 32'h8; clear_buffer = 4'b1000;
        @(negedge clk);
        csr_write = 1'b0; clear_buffer = '0;
        chk("full_set_wins", buf_full, 4'b1010);
        clear_buffer = 4'b0011;
        @(negedge clk);
        clear_buffer = '0;
        chk("full_clear", buf_full, 4'b1000);

        wr(8'h02, 32'h1);
        chk("test_wr_pulse", test_wr, 1'b1);
        chk("wr_busy_set", wr_busy, 1'b1);
        @(negedge clk);
        chk("test_wr_once", test_wr, 1'b0);
        wr(8'h02, 32'h1);
        chk("no_pulse_busy", test_wr, 1'b0);
        rd(8'h03, d); chk("err_start_busy", d, 32'h1);
        wr_finish = 1'b1;
        @(negedge clk);
        wr_finish = 1'b0;
        chk("wr_busy_clr", wr_busy, 1'b0);
        wr(8'h03, 32'h1);
        rd(8'h03, d);
`ifdef DDR3_CSR_IRQ_EN
        chk("err_w1c", d, 32'h8);
`else
        chk("err_w1c", d, 32'h0);
`endif
        wr(8'h03, 32'h1F);

        wr(8'h05, 32'd10);
        wr(8'h02, 32'h2);
        n = 0;
        for (int k = 0; k < 40 && rd_busy; k++) begin
            n++;
            @(negedge clk);
        end
        chk("rd_busy_cycles", 256'(n), 256'd10);
        rd(8'h03, d); chk("err_rd_tmo", d, 32'h4);
        wr(8'h03, 32'h1F);
        wr(8'h02, 32'h2);
        repeat (9) @(negedge clk);
        chk("rd_busy_last", rd_busy, 1'b1);
        rd_finish = 1'b1;
        @(negedge clk);
        rd_finish = 1'b0;
        chk("rd_fin_idle", rd_busy, 1'b0);
        rd(8'h03, d);
`ifdef DDR3_CSR_IRQ_EN
        chk("fin_beats_tmo", d, 32'h10);
`else
        chk("fin_beats_tmo", d, 32'h0);
`endif
        wr(8'h03, 32'h1F);
        wr(8'h05, 32'd0);

        for (int j = 0; j < NW; j++) wr(8'(8'h20 + j), 32'(j + 1));
        chk("wdata", test_wr_data, 128'h00000004_00000003_00000002_00000001);
        test_rd_data = 128'hDEAD << 96;
        rd(8'h33, d); chk("rdata_w3", d, 32'h0000DEAD);
        rd(8'h14, d); chk("offs_unmapped", d, 32'h0);
        rd(8'h24, d); chk("wdat_unmapped", d, 32'h0);

`ifdef DDR3_CSR_IRQ_EN
        wr(8'h06, 32'h08);
        wr(8'h02, 32'h1);
        wr_finish = 1'b1;
        @(negedge clk);
        wr_finish = 1'b0;
        @(negedge clk);
        chk("irq_done", irq, 1'b1);
        wr(8'h03, 32'h08);
        chk("irq_latency", irq, 1'b1);
        @(negedge clk);
        chk("irq_clr", irq, 1'b0);
        wr(8'h06, 32'h0);
`else
        wr(8'h06, 32'h1F);
        rd(8'h06, d); chk("mask_unmapped", d, 32'h0);
        wr(8'h02, 32'h1);
        wr_finish = 1'b1;
        @(negedge clk);
        wr_finish = 1'b0;
        @(negedge clk);
        chk("irq_tied", irq, 1'b0);
`endif

        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                csr_read = 1'b0; clear_buffer = '0; wr_finish = 1'b0; rd_finish = 1'b0;
                wr(8'h05, 32'd0);
                wr(8'h02, 32'h3);
                #3 reset_n = 1'b0;
                @(negedge clk);
                chk("rst_wr_busy", wr_busy, 1'b0);
                chk("rst_rd_busy", rd_busy, 1'b0);
                chk("rst_test_wr", test_wr, 1'b0);
                reset_n = 1'b1;
            end
            csr_read    = ($urandom_range(0, 99) < 30);
            csr_write   = ($urandom_range(0, 99) < 35);
            csr_addr    = addr_tab[$urandom_range(0, 19)];
            csr_wr_data = $urandom;
            if (csr_addr == 8'h05) csr_wr_data = $urandom_range(0, 12);
            clear_buffer = ($urandom_range(0, 3) == 0) ? NB'($urandom_range(0, 15)) : '0;
            wr_finish   = ($urandom_range(0, 99) < 8);
            rd_finish   = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 49) == 0) test_rd_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        csr_read = 1'b0; csr_write = 1'b0; clear_buffer = '0;
        wr_finish = 1'b0; rd_finish = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
